decomplement: RTL

DECOMPLEMENT -- requirements
Module: decomplement

---
 rtl/decomplement.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/decomplement.sv
// decomplement: four-lane two's-complement to sign/magnitude converter behind a
// two-stage valid/ready pipeline (S1: sign/zero/mag, S2: S1 results + lzc).
// Build option COMPLEMENT_LZC_EN: when defined, lzc carries the per-lane
// leading-zero count of mag (W when mag is zero), registered in S2; when
// undefined, lzc is tied to zero and no counting logic exists.
// W normally derives from SIGWIDTH and LOW_EXPAND in parameter.vh; fallback
// values keep this file self-contained when those macros are not defined.

`ifndef SIGWIDTH
`define SIGWIDTH 10
`endif
`ifndef LOW_EXPAND
`define LOW_EXPAND 2
`endif

module decomplement #(
   parameter  int W = `SIGWIDTH + 4 + `LOW_EXPAND,
   localparam int L = $clog2(W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4*W-1:0]   in_num,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       sign,
   output logic [4*W-1:0]   mag,
   output logic [3:0]       zero,
   output logic [4*L-1:0]   lzc
);

   logic             s1_valid;
   logic             s2_valid;
   logic             s1_adv;
   logic             s2_adv;
   logic             accept;

   logic [3:0]       nx_sign;
   logic [3:0]       nx_zero;
   logic [4*W-1:0]   nx_mag;
   logic [W-1:0]     lane;

   logic [3:0]       s1_sign;
   logic [3:0]       s1_zero;
   logic [4*W-1:0]   s1_mag;

   logic [3:0]       s2_sign;
   logic [3:0]       s2_zero;
   logic [4*W-1:0]   s2_mag;

   // S2 frees when empty or being drained; S1 moves forward into a freeing S2,
   // so a full pipe can pop and push in the same cycle.
   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = s1_valid && s2_adv;
   assign in_ready = !s1_valid || s1_adv;
   assign accept   = in_valid && in_ready;

   // Per-lane sign, zero flag and magnitude; the most negative value maps
   // onto itself, which is the correct unsigned magnitude in W bits.
   always_comb begin
      nx_sign = '0;
      nx_zero = '0;
      nx_mag  = '0;
      lane    = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         lane              = in_num[i*W +: W];
         nx_sign[i]        = lane[W-1];
         nx_zero[i]        = (lane == '0);
         nx_mag[i*W +: W]  = lane[W-1] ? (~lane + W'(1)) : lane;
      end
   end

   // Stage 1 register: loads only on an accepted beat, empties when it moves on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= '0;
         s1_zero  <= '0;
         s1_mag   <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_sign  <= nx_sign;
         s1_zero  <= nx_zero;
         s1_mag   <= nx_mag;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2 register: holds while stalled, takes S1 whenever it advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_sign  <= '0;
         s2_zero  <= '0;
         s2_mag   <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_mag  <= s1_mag;
         end
      end
   end

   assign out_valid = s2_valid;
   assign sign      = s2_sign;
   assign zero      = s2_zero;
   assign mag       = s2_mag;

`ifdef COMPLEMENT_LZC_EN
   logic [4*L-1:0]   nx_lzc;
   logic [4*L-1:0]   s2_lzc;

   // Position of the first set bit from the MSB; W when no bit is set.
   function automatic logic [L-1:0] count_lz(input logic [W-1:0] v);
      logic [L-1:0] n;
      logic         hit;
      n   = L'(W);
      hit = 1'b0;
      for (int unsigned i = 0; i < W; i++) begin
         if (!hit && v[W-1-i]) begin
            n   = L'(i);
            hit = 1'b1;
         end
      end
      return n;
   endfunction

   // Leading-zero count of each S1 magnitude, ready for the S2 load.
   always_comb begin
      nx_lzc = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         nx_lzc[i*L +: L] = count_lz(s1_mag[i*W +: W]);
      end
   end

   // lzc travels with the rest of the S2 payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_lzc <= '0;
      end else if (s1_adv) begin
         s2_lzc <= nx_lzc;
      end
   end

   assign lzc = s2_lzc;
`else
   assign lzc = '0;
`endif

endmodule
